serial_word_collect: RTL and testbench
======================================

Name: serial_word_collect

Overview:
- Bit-serial to parallel deserializer for the bit-serial datapath.
- Consumes one LSB-first serial bit per qualified cycle from the bit-serial stage.
- Reassembles WIDTH-bit operand words and presents them on a one-entry valid/ready output buffer to the modular-arithmetic control.
- Detects framing loss and buffer overflow.

Parameters:
- WIDTH, 20, data bits per word; must be >= 2.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- bit_in  in  1  serial data bit
- bit_valid  in  1  bit_in is valid this cycle
- bit_start  in  1  qualified by bit_valid; this bit is bit 0 of a new word
- word_out  out  WIDTH  assembled word, LSB = first received bit
- word_valid  out  1  word_out holds an unconsumed word
- word_ready  in  1  consumer accepts word_out when word_valid & word_ready
- parity_err  out  1  parity status of word_out, qualified by word_valid
- overflow  out  1  sticky: completed word dropped because buffer full
- sync_err  out  1  sticky: bit_start seen mid-word
- clear_err  in  1  clears overflow and sync_err

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, bit counter=0, shift register=0, word_out=0, word_valid=0, parity_err=0, overflow=0, sync_err=0. Reset asserted mid-word discards the partial word.
- A bit is accepted only when bit_valid=1. Cycles with bit_valid=0 are stalls; no state changes.
- Counter width is $clog2(WIDTH+2). An accepted data bit is written to shift-register position cnt.
- IDLE:
  - Valid bits with bit_start=0 are ignored.
  - bit_valid & bit_start: the bit becomes bit 0, cnt=1, go to COLLECT.
- COLLECT:
  - Each accepted bit with bit_start=0 fills position cnt; cnt increments.
  - An accepted bit with bit_start=1 sets sync_err and discards the partial word. That bit is taken as bit 0 and cnt=1. Start has priority, including on the would-be final bit.
  - When the accepted bit is bit WIDTH-1, the word is complete:
    - Without the optional feature: commit the word and go to IDLE.
    - With the optional feature: go to PARITY.
- Commit:
  - At the edge sampling the last bit, the word loads into the output register if the buffer is free or being freed (word_valid=0, or word_ready=1 this cycle).
  - word_valid=1 from the next cycle. Latency is 1 cycle from last-bit sample to word_valid.
  - If the buffer is full (word_valid=1 & word_ready=0), the new word is dropped, overflow is set, and word_out stays unchanged.
- Output:
  - word_valid & word_ready clears word_valid at the edge unless a commit loads the buffer at the same edge.
  - word_out and parity_err are stable while word_valid=1 and not consumed.
- Sticky flags:
  - clear_err clears overflow and sync_err.
  - A new error in the same cycle as clear_err wins; the flag stays set.
- Throughput: back-to-back words with no idle cycle are supported. After a completion, the next word must begin with bit_start.

Optional Feature:
- Macro: SERIAL_COLLECT_PARITY_EN.
- Defined:
  - Each frame carries WIDTH data bits plus one trailing even-parity bit.
  - PARITY state accepts the next valid bit as the parity bit.
  - parity_err = XOR(data bits, parity bit), registered alongside word_out at commit.
  - bit_start during PARITY is handled as in COLLECT: sync_err set, restart.
  - Latency is 1 cycle after the parity bit.
- Undefined:
  - Frame is WIDTH bits; no PARITY state.
  - parity_err is tied to 0.

Decomposition:
- Shared package serial_pkg holds:
  - state enum typedef {IDLE, COLLECT, PARITY}
  - default word-width constant 20
  - counter-width localparam helper
- One natural sub-module: serial_out_buffer. It is the one-entry valid/ready holding register with load/drop/overflow logic. The FSM and shift register stay in the top module.

Test Plan:
- Word 20'hA5A5F sent LSB first, bit_start on bit 0, no gaps, word_ready=1 -> word_valid=1 for one cycle, 1 cycle after the last bit; word_out=20'hA5A5F; no flags.
- Same word with bit_valid toggling 1/0 every cycle -> identical word_out; word_valid one cycle after the 20th valid bit.
- Words 20'h00001 then 20'hFFFFF back to back, word_ready=0 -> word_out holds 20'h00001; overflow=1 after the second word; clear_err -> overflow=0.
- bit_start after 7 bits of a word, then 20 bits of 20'h12345 -> sync_err=1; word_out=20'h12345; the partial word is never output.
- reset pulsed after 10 bits, then a full 20'h0F0F0 frame -> all outputs 0 during reset; word_out=20'h0F0F0; no flags.
- SERIAL_COLLECT_PARITY_EN defined: 20'h00003 with parity 0 -> parity_err=0; same data with parity 1 -> parity_err=1.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and constants for the bit-serial word collector.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package serial_pkg;

    // Word width used when the instantiating design does not override it.
    localparam int DEFAULT_WIDTH = 20;

    // Collector FSM states; PARITY is reachable only when the trailing parity bit is enabled.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PARITY  = 2'd2
    } state_t;

    // Bit counter width: has to reach WIDTH+1 so a frame with a trailing parity bit still fits.
    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/serial_word_collect_if.sv
// Serial bit input, word output and error-flag bundle of the word collector.
// Latency: n/a (wiring only).
// Backpressure: word_ready from the consumer; the serial side is never stalled.
interface serial_word_collect_if import serial_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH);

    logic             bit_in;
    logic             bit_valid;
    logic             bit_start;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;
    logic             parity_err;
    logic             overflow;
    logic             sync_err;
    logic             clear_err;

    // Environment side: drives the serial stream and consumes words.
    modport master (
        output bit_in, bit_valid, bit_start, word_ready, clear_err,
        input  word_out, word_valid, parity_err, overflow, sync_err
    );

    // Collector side.
    modport slave (
        input  bit_in, bit_valid, bit_start, word_ready, clear_err,
        output word_out, word_valid, parity_err, overflow, sync_err
    );

endinterface

// File: rtl/serial_out_buffer.sv
// One-entry valid/ready holding register for assembled words, with sticky overflow.
// Latency: a load is visible on valid/word the cycle after the load edge.
// Backpressure: a load while full and not being drained is dropped and flags overflow.
module serial_out_buffer import serial_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_word,
    input  logic             load_parity,
    input  logic             ready,
    input  logic             clear_err,
    output logic [WIDTH-1:0] word,
    output logic             valid,
    output logic             parity_err,
    output logic             overflow
);

    logic free;
    logic accept_load;
    logic drop;

    // The slot can take a new word when it is empty or being consumed this same cycle.
    always_comb begin
        free        = !valid || ready;
        accept_load = load && free;
        drop        = load && !free;
    end

    // Holding register: load wins over a simultaneous drain so back-to-back words never gap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
        end else if (accept_load) begin
            word       <= load_word;
            valid      <= 1'b1;
            parity_err <= load_parity;
        end else if (valid && ready) begin
            valid      <= 1'b0;
        end
    end

    // Sticky overflow: a drop in the same cycle as clear_err keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_err) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_word_collect.sv
// LSB-first bit-serial to WIDTH-bit word deserializer with framing and overflow detection.
// Latency: word_valid rises 1 cycle after the last data bit (or the parity bit with SERIAL_COLLECT_PARITY_EN).
// Backpressure: none toward the serial side; a finished word meeting a full buffer is dropped (overflow).
module serial_word_collect import serial_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic                clk,
    input logic                reset,
    serial_word_collect_if.slave bus
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;

    logic             restart;
    logic             data_bit;
    logic             last_data;
    logic             sync_set;
    logic             commit;
    logic [WIDTH-1:0] shreg_ins;
    logic [WIDTH-1:0] commit_word;
    logic             commit_parity;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: a start bit always (re)opens a frame; completion returns to IDLE or awaits parity.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (restart) begin
                    state_nx = COLLECT;
                end
            end
            COLLECT: begin
                if (restart) begin
                    state_nx = COLLECT;
                end else if (last_data) begin
`ifdef SERIAL_COLLECT_PARITY_EN
                    state_nx = PARITY;
`else
                    state_nx = IDLE;
`endif
                end
            end
            PARITY: begin
                if (restart) begin
                    state_nx = COLLECT;
                end else if (bus.bit_valid) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Per-cycle decodes: bit classification, mid-frame start detection and the commit request.
    always_comb begin
        restart   = bus.bit_valid && bus.bit_start;
        data_bit  = (state == COLLECT) && bus.bit_valid && !bus.bit_start;
        last_data = data_bit && (cnt == LAST);
        sync_set  = restart && (state != IDLE);
        shreg_ins = shreg;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt == CW'(i)) begin
                shreg_ins[i] = bus.bit_in;
            end
        end
`ifdef SERIAL_COLLECT_PARITY_EN
        commit        = (state == PARITY) && bus.bit_valid && !bus.bit_start;
        commit_word   = shreg;
        commit_parity = ^{shreg, bus.bit_in};
`else
        commit        = last_data;
        commit_word   = shreg_ins;
        commit_parity = 1'b0;
`endif
    end

    // Shift register and bit counter: a start bit discards any partial word and becomes bit 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (restart) begin
            cnt   <= CW'(1);
            shreg <= {{(WIDTH-1){1'b0}}, bus.bit_in};
        end else if (commit) begin
            cnt   <= '0;
        end else if (data_bit) begin
            cnt   <= cnt + CW'(1);
            shreg <= shreg_ins;
        end
    end

    // Sticky framing error: a new mid-frame start beats a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.sync_err <= 1'b0;
        end else if (sync_set) begin
            bus.sync_err <= 1'b1;
        end else if (bus.clear_err) begin
            bus.sync_err <= 1'b0;
        end
    end

    serial_out_buffer #(.WIDTH(WIDTH)) u_out_buffer (
        .clk         (clk),
        .reset       (reset),
        .load        (commit),
        .load_word   (commit_word),
        .load_parity (commit_parity),
        .ready       (bus.word_ready),
        .clear_err   (bus.clear_err),
        .word        (bus.word_out),
        .valid       (bus.word_valid),
        .parity_err  (bus.parity_err),
        .overflow    (bus.overflow)
    );

endmodule

// File: tb/tb_serial_word_collect.sv
// Directed and randomized bench for serial_word_collect against a frame-level reference.
// Latency: expects word_valid the cycle after the final bit of a frame.
// Backpressure: drives word_ready low to provoke overflow, high elsewhere.
module tb_serial_word_collect;

    localparam int W = 20;
`ifdef SERIAL_COLLECT_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    logic [W-1:0] cap[$];
    logic [W-1:0] exp_q[$];

    serial_word_collect_if #(.WIDTH(W)) bus();

    serial_word_collect #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Record every word handed over (valid & ready seen away from the clock edge).
    always @(negedge clk) begin
        if (bus.word_valid && bus.word_ready) begin
            cap.push_back(bus.word_out);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drive_bit(input logic b, input logic s);
        bus.bit_in    = b;
        bus.bit_valid = 1'b1;
        bus.bit_start = s;
        step();
        bus.bit_valid = 1'b0;
        bus.bit_start = 1'b0;
    endtask

    // gap_mode: 0 = no gaps, 1 = one idle cycle between bits, 2 = random 0..2 idle cycles.
    task automatic send_word(input logic [W-1:0] w, input int gap_mode, input logic flip);
        int nbits;
        logic [W:0] frame;
        nbits = PAR ? W + 1 : W;
        frame = {(^w) ^ flip, w};
        for (int i = 0; i < nbits; i++) begin
            drive_bit(frame[i], (i == 0));
            if (i != nbits - 1) begin
                if (gap_mode == 1) step();
                else if (gap_mode == 2) repeat ($urandom_range(0, 2)) step();
            end
        end
    endtask

    initial begin
        logic [W-1:0] w;
        logic         flip;
        logic         exp_sync;
        logic [31:0]  first;
        int           k;

        bus.bit_in     = 1'b0;
        bus.bit_valid  = 1'b0;
        bus.bit_start  = 1'b0;
        bus.word_ready = 1'b1;
        bus.clear_err  = 1'b0;
        step();
        step();
        check("rst_valid", 32'(bus.word_valid), 32'd0);
        check("rst_word", 32'(bus.word_out), 32'd0);
        check("rst_parity", 32'(bus.parity_err), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_sync", 32'(bus.sync_err), 32'd0);
        reset = 1'b0;
        step();

        // Gapless frame, consumer always ready.
        send_word(20'hA5A5F, 0, 1'b0);
        check("t1_valid", 32'(bus.word_valid), 32'd1);
        check("t1_word", 32'(bus.word_out), 32'hA5A5F);
        check("t1_parity", 32'(bus.parity_err), 32'd0);
        check("t1_overflow", 32'(bus.overflow), 32'd0);
        check("t1_sync", 32'(bus.sync_err), 32'd0);
        step();
        check("t1_valid_drop", 32'(bus.word_valid), 32'd0);

        // Same frame with bit_valid toggling.
        send_word(20'hA5A5F, 1, 1'b0);
        check("t2_valid", 32'(bus.word_valid), 32'd1);
        check("t2_word", 32'(bus.word_out), 32'hA5A5F);
        step();
        check("t2_valid_drop", 32'(bus.word_valid), 32'd0);

        // Back-to-back words into a stalled consumer.
        bus.word_ready = 1'b0;
        send_word(20'h00001, 0, 1'b0);
        check("t3_first_valid", 32'(bus.word_valid), 32'd1);
        check("t3_first_word", 32'(bus.word_out), 32'h00001);
        check("t3_no_ovf_yet", 32'(bus.overflow), 32'd0);
        send_word(20'hFFFFF, 0, 1'b0);
        check("t3_hold_word", 32'(bus.word_out), 32'h00001);
        check("t3_hold_valid", 32'(bus.word_valid), 32'd1);
        check("t3_overflow", 32'(bus.overflow), 32'd1);
        bus.clear_err = 1'b1;
        step();
        bus.clear_err = 1'b0;
        check("t3_ovf_clear", 32'(bus.overflow), 32'd0);
        bus.word_ready = 1'b1;
        step();
        check("t3_drained", 32'(bus.word_valid), 32'd0);

        // Start bit mid-word: partial word discarded, sync_err set.
        cap.delete();
        for (int i = 0; i < 7; i++) drive_bit(1'($urandom()), (i == 0));
        send_word(20'h12345, 0, 1'b0);
        check("t4_sync", 32'(bus.sync_err), 32'd1);
        check("t4_word", 32'(bus.word_out), 32'h12345);
        step();
        check("t4_one_word", 32'(cap.size()), 32'd1);
        first = (cap.size() > 0) ? 32'(cap[0]) : 32'hxxxxxxxx;
        check("t4_cap_word", first, 32'h12345);
        bus.clear_err = 1'b1;
        step();
        bus.clear_err = 1'b0;
        check("t4_sync_clear", 32'(bus.sync_err), 32'd0);

        // Asynchronous reset in the middle of a frame.
        for (int i = 0; i < 10; i++) drive_bit(1'b1, (i == 0));
        #2;
        reset = 1'b1;
        #1;
        check("t5_rst_valid", 32'(bus.word_valid), 32'd0);
        check("t5_rst_word", 32'(bus.word_out), 32'd0);
        check("t5_rst_sync", 32'(bus.sync_err), 32'd0);
        check("t5_rst_ovf", 32'(bus.overflow), 32'd0);
        step();
        reset = 1'b0;
        step();
        send_word(20'h0F0F0, 0, 1'b0);
        check("t5_word", 32'(bus.word_out), 32'h0F0F0);
        check("t5_valid", 32'(bus.word_valid), 32'd1);
        check("t5_sync", 32'(bus.sync_err), 32'd0);
        check("t5_ovf", 32'(bus.overflow), 32'd0);
        step();

`ifdef SERIAL_COLLECT_PARITY_EN
        // Trailing parity bit: correct, then inverted.
        send_word(20'h00003, 0, 1'b0);
        check("t6_par_ok_word", 32'(bus.word_out), 32'h00003);
        check("t6_par_ok", 32'(bus.parity_err), 32'd0);
        step();
        send_word(20'h00003, 0, 1'b1);
        check("t6_par_bad", 32'(bus.parity_err), 32'd1);
        step();
`endif

        // Randomized frames with stalls, idle noise and aborted partial frames.
        cap.delete();
        exp_q.delete();
        exp_sync = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(1, 4);
                for (int i = 0; i < k; i++) drive_bit(1'($urandom()), 1'b0);
            end
            if ($urandom_range(0, 4) == 0) begin
                k = $urandom_range(1, W - 1);
                for (int i = 0; i < k; i++) drive_bit(1'($urandom()), (i == 0));
                exp_sync = 1'b1;
            end
            w    = W'($urandom());
            flip = PAR ? 1'($urandom()) : 1'b0;
            send_word(w, 2, flip);
            check("rnd_valid", 32'(bus.word_valid), 32'd1);
            check("rnd_word", 32'(bus.word_out), 32'(w));
            check("rnd_parity", 32'(bus.parity_err), 32'(flip));
            exp_q.push_back(w);
            repeat ($urandom_range(0, 2)) step();
        end
        step();
        step();
        check("rnd_count", 32'(cap.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            check("rnd_stream", 32'(cap[i]), 32'(exp_q[i]));
        end
        check("rnd_sync", 32'(bus.sync_err), 32'(exp_sync));
        check("rnd_ovf", 32'(bus.overflow), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
